gppcu_cond_mask_unit: RTL
=========================

GPPCU_COND_MASK_UNIT -- requirements
Module: GPPCU_COND_MASK_UNIT

Interface
REQ-001 SHALL have parameter NUM_LANE, default 8: number of SIMD lanes (1..32).
REQ-002 SHALL have parameter STACK_DEPTH, default 4: mask-stack entries (2..16).
REQ-003 SHALL have port iCLK  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port iRSTn  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port iOP  in  2  mask operation: 0 NOP, 1 PUSH_IF, 2 ELSE, 3 POP.
REQ-006 SHALL have port iOP_COND  in  4  condition code used by PUSH_IF, using the COND_* encodings of GPPCU_PARAMETERS.vh.
REQ-007 SHALL have port iSREG_WE  in  1  status-flag write strobe.
REQ-008 SHALL have port iSREG  in  5*NUM_LANE  new flags, lane k in bits [5k+4:5k], with bit positions given by SREG_*.
REQ-009 SHALL have port oSREG  out  5*NUM_LANE  registered per-lane flags.
REQ-010 SHALL have port oMASK  out  NUM_LANE  registered lane-active mask.
REQ-011 SHALL have port oDEPTH  out  clog2(STACK_DEPTH+1)  number of stacked entries.
REQ-012 SHALL have port oERR  out  1  sticky stack error.

Function
REQ-013 SHALL evaluate the condition per lane from registered oSREG as follows:
- ALWAYS is 1 and NEVER is 0.
- C, NC, Z, NZ, V, NV, N and NN are the flag or its inverse.
- NEG and LT are (~V&N)|(V&C).
- POS and GR are (~V&~N)|(V&~C).
- EQ is ~C&Z.
- Any unassigned code evaluates to 0.
REQ-014 SHALL, on iSREG_WE=1, load lane k's flags only where oMASK[k]=1; inactive lanes hold their flags.
REQ-015 SHALL, on PUSH_IF, push oMASK onto the stack, set oMASK <= oMASK & cond, and increment oDEPTH.
REQ-016 SHALL, on ELSE with oDEPTH>0, set oMASK <= top & ~oMASK; the stack and oDEPTH are unchanged.
REQ-017 SHALL, on POP with oDEPTH>0, set oMASK <= top and decrement oDEPTH.
REQ-018 SHALL register all outputs; a change is visible the cycle after the triggering edge (latency 1); there is no stall and an op is accepted every cycle.
REQ-019 SHALL, when iSREG_WE and PUSH_IF occur in the same cycle, evaluate the condition on pre-write flags and gate the write with the pre-update mask.
REQ-020 SHALL, on ELSE with oDEPTH=0, treat top as all-ones.
REQ-021 SHALL treat NOP as holding mask, stack and depth.

Reset
REQ-022 SHALL, while iRSTn=0 and independent of iCLK, force oMASK to all ones, oDEPTH to 0, oSREG to 0, oERR to 0 and every stack entry to 0.
REQ-023 SHALL abandon any in-flight op on reset assertion; the first edge after deassertion processes inputs normally.

Configuration
REQ-024 SHALL use macro GPPCU_COND_STACK_CHECK_EN to select stack-boundary handling.
REQ-025 SHALL, with the macro defined, behave as follows:
- PUSH_IF at oDEPTH=STACK_DEPTH leaves mask, stack and depth unchanged and sets oERR.
- POP at oDEPTH=0 leaves state unchanged and sets oERR.
- oERR clears only by reset.
REQ-026 SHALL, without the macro, behave as follows:
- PUSH_IF when full overwrites the top entry, applies the mask update, and leaves depth at STACK_DEPTH.
- POP when empty sets oMASK to all ones.
- oERR is tied to 0.

Verification
REQ-027 SHALL cover reset: NUM_LANE=4, release iRSTn -> oMASK=4'b1111, oDEPTH=0, oSREG=0, oERR=0.
REQ-028 SHALL cover PUSH_IF then ELSE: lane Z flags {1,0,1,0} (lane3..0), PUSH_IF COND_Z -> oMASK=1010 and oDEPTH=1; ELSE -> 0101; POP -> 1111 and oDEPTH=0.
REQ-029 SHALL cover the masked write: oMASK=0011, iSREG_WE with all flags 1 -> only lanes 0 and 1 show 5'b11111.
REQ-030 SHALL cover a simultaneous write and push: flags 0, same cycle iSREG_WE sets C=1 and PUSH_IF COND_C -> oMASK=0000 (old flags used), and all active lanes' C=1.
REQ-031 SHALL cover overflow with the macro defined: STACK_DEPTH=2, three PUSH_IF COND_ALWAYS -> oDEPTH=2, oERR=1; POP x3 -> oDEPTH=0, oMASK=1111, oERR stays 1.
REQ-032 SHALL cover empty pop without the macro: POP at depth 0 -> oMASK=1111, oERR=0.

Source files
------------

// File: rtl/gppcu_cond_mask_unit.sv
// rtl/gppcu_cond_mask_unit.sv - SIMD lane mask stack with per-lane condition flags
// Optional macro GPPCU_COND_STACK_CHECK_EN: reject stack overflow/underflow and flag oERR.
module gppcu_cond_mask_unit #(
    parameter int NUM_LANE    = 8,
    parameter int STACK_DEPTH = 4,
    localparam int DEPTH_W    = $clog2(STACK_DEPTH + 1)
) (
    input  logic                    iCLK,
    input  logic                    iRSTn,
    input  logic [1:0]              iOP,
    input  logic [3:0]              iOP_COND,
    input  logic                    iSREG_WE,
    input  logic [5*NUM_LANE-1:0]   iSREG,
    output logic [5*NUM_LANE-1:0]   oSREG,
    output logic [NUM_LANE-1:0]     oMASK,
    output logic [DEPTH_W-1:0]      oDEPTH,
    output logic                    oERR
);
    localparam logic [1:0] OP_NOP = 2'd0;
    localparam logic [1:0] OP_PUSH_IF = 2'd1;
    localparam logic [1:0] OP_ELSE = 2'd2;
    localparam logic [1:0] OP_POP = 2'd3;

    localparam int SREG_C = 0;
    localparam int SREG_Z = 1;
    localparam int SREG_V = 2;
    localparam int SREG_N = 3;

    localparam logic [3:0] COND_ALWAYS = 4'd0;
    localparam logic [3:0] COND_NEVER = 4'd1;
    localparam logic [3:0] COND_C = 4'd2;
    localparam logic [3:0] COND_NC = 4'd3;
    localparam logic [3:0] COND_Z = 4'd4;
    localparam logic [3:0] COND_NZ = 4'd5;
    localparam logic [3:0] COND_V = 4'd6;
    localparam logic [3:0] COND_NV = 4'd7;
    localparam logic [3:0] COND_N = 4'd8;
    localparam logic [3:0] COND_NN = 4'd9;
    localparam logic [3:0] COND_NEG = 4'd10;
    localparam logic [3:0] COND_POS = 4'd11;
    localparam logic [3:0] COND_LT = 4'd12;
    localparam logic [3:0] COND_GR = 4'd13;
    localparam logic [3:0] COND_EQ = 4'd14;

    logic [NUM_LANE-1:0] stackQ [STACK_DEPTH];
    logic [NUM_LANE-1:0] condVec;
    logic [NUM_LANE-1:0] topMask;
    logic [NUM_LANE-1:0] maskD;
    logic [DEPTH_W-1:0]  depthD;
    logic [DEPTH_W-1:0]  stackWrIdx;
    logic                stackWe;
    logic                errD;
    logic                stackFull;
    logic                stackEmpty;

    always_comb begin
        for (int k = 0; k < NUM_LANE; k++) begin
            logic c, z, v, n;
            c = oSREG[5*k + SREG_C];
            z = oSREG[5*k + SREG_Z];
            v = oSREG[5*k + SREG_V];
            n = oSREG[5*k + SREG_N];
            case (iOP_COND)
                COND_ALWAYS:      condVec[k] = 1'b1;
                COND_NEVER:       condVec[k] = 1'b0;
                COND_C:           condVec[k] = c;
                COND_NC:          condVec[k] = ~c;
                COND_Z:           condVec[k] = z;
                COND_NZ:          condVec[k] = ~z;
                COND_V:           condVec[k] = v;
                COND_NV:          condVec[k] = ~v;
                COND_N:           condVec[k] = n;
                COND_NN:          condVec[k] = ~n;
                COND_NEG, COND_LT: condVec[k] = (~v & n) | (v & c);
                COND_POS, COND_GR: condVec[k] = (~v & ~n) | (v & ~c);
                COND_EQ:          condVec[k] = ~c & z;
                default:          condVec[k] = 1'b0;
            endcase
        end
    end

    // An empty stack reads as all-ones so ELSE at depth 0 inverts the mask.
    always_comb begin
        topMask = '1;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (oDEPTH == DEPTH_W'(i + 1)) topMask = stackQ[i];
        end
    end

    assign stackFull  = (oDEPTH == DEPTH_W'(STACK_DEPTH));
    assign stackEmpty = (oDEPTH == '0);

    always_comb begin
        maskD      = oMASK;
        depthD     = oDEPTH;
        errD       = oERR;
        stackWe    = 1'b0;
        stackWrIdx = oDEPTH;
        case (iOP)
            OP_PUSH_IF: begin
                if (!stackFull) begin
                    stackWe = 1'b1;
                    maskD   = oMASK & condVec;
                    depthD  = oDEPTH + 1'b1;
                end else begin
`ifdef GPPCU_COND_STACK_CHECK_EN
                    errD = 1'b1;
`else
                    stackWe    = 1'b1;
                    stackWrIdx = DEPTH_W'(STACK_DEPTH - 1);
                    maskD      = oMASK & condVec;
`endif
                end
            end
            OP_ELSE: maskD = topMask & ~oMASK;
            OP_POP: begin
                if (!stackEmpty) begin
                    maskD  = topMask;
                    depthD = oDEPTH - 1'b1;
                end else begin
`ifdef GPPCU_COND_STACK_CHECK_EN
                    errD = 1'b1;
`else
                    maskD = '1;
`endif
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            oMASK  <= '1;
            oDEPTH <= '0;
            oSREG  <= '0;
            oERR   <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) stackQ[i] <= '0;
        end else begin
            oMASK  <= maskD;
            oDEPTH <= depthD;
            oERR   <= errD;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                if (stackWe && stackWrIdx == DEPTH_W'(i)) stackQ[i] <= oMASK;
            end
            // Flag writes are gated by the mask in effect before this edge's op.
            for (int k = 0; k < NUM_LANE; k++) begin
                if (iSREG_WE && oMASK[k]) oSREG[5*k +: 5] <= iSREG[5*k +: 5];
            end
        end
    end
endmodule
